// File: rtl/psum_buffer_pkg.sv
// Shared conv-side definitions for the partial-sum buffer: default widths and FSM encoding.
package psum_buffer_pkg;

  localparam int unsigned DataWidthDef = 32;
  localparam int unsigned AddrWidthDef = 16;
  localparam int unsigned DepthDef     = 4096;

  typedef enum logic {
    SERVE = 1'b0,
    DRAIN = 1'b1
  } psum_state_e;

endpackage

// File: rtl/psum_buffer_ram.sv
// Partial-sum storage: one write port, two registered read ports, write-first on address match.
module psum_ram #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 4096,
  parameter int unsigned RamAw     = 12
) (
  input  logic                 Clk,
  input  logic                 wr_en,
  input  logic [RamAw-1:0]     wr_addr,
  input  logic [DataWidth-1:0] wr_data,
  input  logic [RamAw-1:0]     rd_addr_a,
  output logic [DataWidth-1:0] rd_data_a,
  input  logic [RamAw-1:0]     rd_addr_b,
  output logic [DataWidth-1:0] rd_data_b
);

  logic [DataWidth-1:0] mem [Depth];

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_a <= (wr_en && (wr_addr == rd_addr_a)) ? wr_data : mem[rd_addr_a];
    rd_data_b <= (wr_en && (wr_addr == rd_addr_b)) ? wr_data : mem[rd_addr_b];
  end

endmodule

// File: rtl/psum_buffer.sv
// Accumulator partial-sum buffer: serves conv-side reads/writes, then streams final results
// out through a two-entry skid with optional ReLU clamping.
module psum_buffer
  import psum_buffer_pkg::*;
#(
  parameter int unsigned DataWidth = DataWidthDef,
  parameter int unsigned AddrWidth = AddrWidthDef,
  parameter int unsigned Depth     = DepthDef
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [AddrWidth-1:0] rd_addr_conv,
  output logic [DataWidth-1:0] rd_data_conv,
  input  logic [AddrWidth-1:0] wr_addr_conv,
  input  logic [DataWidth-1:0] wr_data_conv,
  input  logic                 wr_en_conv,
  input  logic                 drain_start,
  input  logic [AddrWidth-1:0] drain_len,
  input  logic                 relu_en,
  output logic [DataWidth-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 drain_done,
  output logic                 err
);

  localparam int unsigned CntW  = AddrWidth + 1;
  localparam int unsigned RamAw = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntW-1:0] DepthC = CntW'(Depth);

  psum_state_e          state_q;
  logic [CntW-1:0]      len_q;
  logic [CntW-1:0]      issue_cnt_q;
  logic [CntW-1:0]      beat_cnt_q;
  logic                 relu_q;
  logic                 inflight_q;
  logic                 rd_zero_q;
  logic                 out_valid_q;
  logic                 drain_done_q;
  logic                 err_q;
  logic [1:0]           count_q;
  logic [DataWidth-1:0] head_q;
  logic [DataWidth-1:0] skid_q;

  logic                 rd_oob_c;
  logic                 wr_oob_c;
  logic                 wr_ok_c;
  logic                 start_c;
  logic                 len_clamp_c;
  logic [CntW-1:0]      len_eff_c;
  logic                 pop_c;
  logic                 last_beat_c;
  logic                 issue_c;
  logic [2:0]           occ_c;
  logic [1:0]           count_next_c;
  logic [RamAw-1:0]     drain_addr_c;
  logic [DataWidth-1:0] ram_rd_a;
  logic [DataWidth-1:0] ram_rd_b;
  logic [DataWidth-1:0] push_data_c;

  psum_ram #(
    .DataWidth(DataWidth),
    .Depth    (Depth),
    .RamAw    (RamAw)
  ) u_ram (
    .Clk      (Clk),
    .wr_en    (wr_ok_c),
    .wr_addr  (RamAw'(wr_addr_conv)),
    .wr_data  (wr_data_conv),
    .rd_addr_a(RamAw'(rd_addr_conv)),
    .rd_data_a(ram_rd_a),
    .rd_addr_b(drain_addr_c),
    .rd_data_b(ram_rd_b)
  );

  // Drain issue credit: a read may be launched only if its data will find a free skid slot.
  always_comb begin
    rd_oob_c     = {1'b0, rd_addr_conv} >= DepthC;
    wr_oob_c     = {1'b0, wr_addr_conv} >= DepthC;
    wr_ok_c      = wr_en_conv && !wr_oob_c && (state_q == SERVE);
    start_c      = drain_start && (state_q == SERVE);
    len_clamp_c  = {1'b0, drain_len} > DepthC;
    len_eff_c    = len_clamp_c ? DepthC : {1'b0, drain_len};
    pop_c        = out_valid_q && out_ready;
    last_beat_c  = (state_q == DRAIN) && pop_c && (beat_cnt_q == (len_q - CntW'(1)));
    occ_c        = 3'(count_q) + 3'(inflight_q) - 3'(pop_c);
    issue_c      = 1'b0;
    if (start_c) begin
      issue_c = (len_eff_c != '0);
    end else if (state_q == DRAIN) begin
      issue_c = (issue_cnt_q < len_q) && (occ_c <= 3'd1);
    end
    drain_addr_c = (state_q == DRAIN) ? RamAw'(issue_cnt_q) : '0;
    push_data_c  = (relu_q && ram_rd_b[DataWidth-1]) ? '0 : ram_rd_b;
    count_next_c = count_q + 2'(inflight_q) - 2'(pop_c);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= SERVE;
      len_q        <= '0;
      issue_cnt_q  <= '0;
      beat_cnt_q   <= '0;
      relu_q       <= 1'b0;
      inflight_q   <= 1'b0;
      rd_zero_q    <= 1'b1;
      out_valid_q  <= 1'b0;
      drain_done_q <= 1'b0;
      err_q        <= 1'b0;
      count_q      <= '0;
      head_q       <= '0;
      skid_q       <= '0;
    end else begin
      drain_done_q <= 1'b0;
      rd_zero_q    <= rd_oob_c || (state_q == DRAIN);
      inflight_q   <= issue_c;
      if ((wr_en_conv && (wr_oob_c || (state_q == DRAIN))) ||
          (rd_oob_c && (state_q == SERVE)) || (start_c && len_clamp_c)) begin
        err_q <= 1'b1;
      end

      case (state_q)
        SERVE: begin
          if (drain_start) begin
            if (len_eff_c == '0) begin
              drain_done_q <= 1'b1;
            end else begin
              state_q     <= DRAIN;
              len_q       <= len_eff_c;
              relu_q      <= relu_en;
              beat_cnt_q  <= '0;
              issue_cnt_q <= CntW'(1);
            end
          end
        end
        DRAIN: begin
          if (issue_c) begin
            issue_cnt_q <= issue_cnt_q + CntW'(1);
          end
          if (pop_c) begin
            beat_cnt_q <= beat_cnt_q + CntW'(1);
          end
          if (last_beat_c) begin
            state_q      <= SERVE;
            drain_done_q <= 1'b1;
          end
        end
      endcase

      // Two-entry skid: head drives the stream, skid absorbs the in-flight word under stall.
      if (inflight_q && pop_c) begin
        if (count_q == 2'd2) begin
          head_q <= skid_q;
          skid_q <= push_data_c;
        end else begin
          head_q <= push_data_c;
        end
      end else if (inflight_q) begin
        if (count_q == 2'd0) begin
          head_q <= push_data_c;
        end else begin
          skid_q <= push_data_c;
        end
      end else if (pop_c && (count_q == 2'd2)) begin
        head_q <= skid_q;
      end
      count_q     <= count_next_c;
      out_valid_q <= (count_next_c != 2'd0);
    end
  end

  assign rd_data_conv = rd_zero_q ? '0 : ram_rd_a;
  assign out_data     = head_q;
  assign out_valid    = out_valid_q;
  assign busy         = (state_q == DRAIN);
  assign drain_done   = drain_done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_psum_buffer.sv
// Scoreboard bench for psum_buffer: stimulus queues expected responses, a negedge monitor checks them.
module tb_psum_buffer;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 16;
  localparam int unsigned DEPTH = 16;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [AW-1:0] rd_addr_conv;
  logic [DW-1:0] rd_data_conv;
  logic [AW-1:0] wr_addr_conv;
  logic [DW-1:0] wr_data_conv;
  logic          wr_en_conv;
  logic          drain_start;
  logic [AW-1:0] drain_len;
  logic          relu_en;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          drain_done;
  logic          err;

  psum_buffer #(.DataWidth(DW), .AddrWidth(AW), .Depth(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst),
    .rd_addr_conv(rd_addr_conv), .rd_data_conv(rd_data_conv),
    .wr_addr_conv(wr_addr_conv), .wr_data_conv(wr_data_conv), .wr_en_conv(wr_en_conv),
    .drain_start(drain_start), .drain_len(drain_len), .relu_en(relu_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .drain_done(drain_done), .err(err)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] val;
  } rd_exp_t;

  rd_exp_t     rd_q[$];
  logic [31:0] out_q[$];
  int          done_q[$];
  bit          done_seen = 1'b0;
  int          first_due = -1;
  int          last_beat = -1;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [31:0] data);
    wr_en_conv   = 1'b1;
    wr_addr_conv = AW'(addr);
    wr_data_conv = data;
    tick();
    wr_en_conv   = 1'b0;
  endtask

  task automatic run_drain(input int len, input bit relu, input bit toggle, input int done_rel);
    done_seen   = 1'b0;
    drain_start = 1'b1;
    drain_len   = AW'(len);
    relu_en     = relu;
    out_ready   = 1'b1;
    first_due   = (len > 0) ? cyc + 2 : -1;
    done_q.push_back((done_rel < 0) ? -1 : cyc + done_rel);
    tick();
    drain_start = 1'b0;
    drain_len   = '0;
    relu_en     = 1'b0;
    for (int n = 0; n < 300 && !done_seen; n++) begin
      if (toggle) out_ready = ~out_ready;
      if (len == 0) chk("busy_idle", 32'(busy), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    chk("drain_completed", 32'(done_seen), 32'd1);
    chk("drain_leftover", 32'(out_q.size()), 32'd0);
  endtask

  // Monitor: conv reads by due cycle, stream beats in order, drain_done timing.
  always @(negedge Clk) begin : monitor
    rd_exp_t e;
    int      d;
    while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
      e = rd_q.pop_front();
      if (e.due < cyc) chk("rd_missed", 32'(cyc), 32'(e.due));
      else chk("rd_data_conv", rd_data_conv, e.val);
    end
    if (out_valid) begin
      if (first_due >= 0) begin
        chk("first_valid_cycle", 32'(cyc), 32'(first_due));
        first_due = -1;
      end
      if (out_q.size() == 0) begin
        chk("unexpected_beat", 32'(out_q.size()), 32'd1);
      end else begin
        chk("out_data", out_data, out_q[0]);
        if (out_ready) begin
          void'(out_q.pop_front());
          last_beat = cyc;
        end
      end
    end
    if (drain_done) begin
      done_seen = 1'b1;
      if (done_q.size() == 0) begin
        chk("unexpected_done", 32'(done_q.size()), 32'd1);
      end else begin
        d = done_q.pop_front();
        chk("drain_done_cycle", 32'(cyc), (d < 0) ? 32'(last_beat + 1) : 32'(d));
      end
    end
  end

  initial begin
    Rst          = 1'b1;
    rd_addr_conv = '0;
    wr_addr_conv = '0;
    wr_data_conv = '0;
    wr_en_conv   = 1'b0;
    drain_start  = 1'b0;
    drain_len    = '0;
    relu_en      = 1'b0;
    out_ready    = 1'b1;
    repeat (3) tick();
    chk("rst_rd_data", rd_data_conv, 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drain_done", 32'(drain_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    Rst = 1'b0;
    tick();

    // Write then read next cycle.
    wr(5, 32'h40400000);
    rd_addr_conv = AW'(5);
    rd_q.push_back('{cyc + 1, 32'h40400000});
    tick();
    rd_addr_conv = '0;

    // Same-cycle write/read forwards the new word.
    wr_en_conv   = 1'b1;
    wr_addr_conv = AW'(7);
    wr_data_conv = 32'h3F800000;
    rd_addr_conv = AW'(7);
    rd_q.push_back('{cyc + 1, 32'h3F800000});
    tick();
    wr_en_conv   = 1'b0;
    rd_addr_conv = '0;

    // Full-rate drain of 0..7.
    for (int i = 0; i < 8; i++) wr(i, 32'(i));
    for (int i = 0; i < 8; i++) out_q.push_back(32'(i));
    run_drain(8, 1'b0, 1'b0, 10);

    // Same drain under alternating back-pressure.
    for (int i = 0; i < 8; i++) out_q.push_back(32'(i));
    run_drain(8, 1'b0, 1'b1, -1);

    // ReLU clamps the negative word only.
    wr(0, 32'hBF800000);
    wr(1, 32'h40000000);
    out_q.push_back(32'h00000000);
    out_q.push_back(32'h40000000);
    run_drain(2, 1'b1, 1'b0, 4);

    // Out-of-range write is dropped and flagged; zero-length drain.
    chk("err_before_oob", 32'(err), 32'd0);
    wr(DEPTH, 32'hDEADBEEF);
    chk("err_after_oob", 32'(err), 32'd1);
    run_drain(0, 1'b0, 1'b0, 1);
    rd_addr_conv = '0;
    rd_q.push_back('{cyc + 1, 32'hBF800000});
    tick();
    tick();

    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("rst2_err", 32'(err), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd0);
    tick();

    // Oversized drain length is clamped to the full depth.
    for (int i = 0; i < int'(DEPTH); i++) wr(i, 32'h100 + 32'(i));
    for (int i = 0; i < int'(DEPTH); i++) out_q.push_back(32'h100 + 32'(i));
    run_drain(20, 1'b0, 1'b0, 2 + int'(DEPTH));
    chk("err_clamp", 32'(err), 32'd1);

    // Reset mid-drain: no drain_done, conv reads returned zero while draining, memory kept.
    out_ready   = 1'b0;
    drain_start = 1'b1;
    drain_len   = AW'(8);
    first_due   = cyc + 2;
    for (int i = 0; i < 8; i++) out_q.push_back(32'h100 + 32'(i));
    tick();
    drain_start = 1'b0;
    drain_len   = '0;
    for (int j = 0; j < 3; j++) begin
      rd_addr_conv = AW'(2);
      rd_q.push_back('{cyc + 1, 32'h0});
      tick();
    end
    chk("busy_in_drain", 32'(busy), 32'd1);
    rd_addr_conv = '0;
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    out_q.delete();
    first_due = -1;
    out_ready = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    done_seen = 1'b0;
    repeat (5) tick();
    chk("abort_no_done", 32'(done_seen), 32'd0);
    rd_addr_conv = AW'(2);
    rd_q.push_back('{cyc + 1, 32'h102});
    tick();
    rd_addr_conv = '0;
    tick();
    tick();

    chk("rd_queue_empty", 32'(rd_q.size()), 32'd0);
    chk("done_queue_empty", 32'(done_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
